// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: pipe-register enables/flushes,
// PC enable, cache request gating, halt drain and saturating performance counters.
module pipeline_ctrl #(
  parameter int unsigned PERF_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ihit,
  input  logic              i_dhit,
  input  logic              i_mem_dren,
  input  logic              i_mem_dwen,
  input  logic              i_ex_dren,
  input  logic [4:0]        i_ex_wsel,
  input  logic [4:0]        i_id_rs,
  input  logic [4:0]        i_id_rt,
  input  logic              i_id_uses_rt,
  input  logic              i_ex_redirect,
  input  logic              i_wb_halt,
  output logic              o_pc_en,
  output logic              o_if_id_en,
  output logic              o_if_id_flush,
  output logic              o_id_ex_en,
  output logic              o_id_ex_flush,
  output logic              o_ex_mem_en,
  output logic              o_ex_mem_flush,
  output logic              o_mem_wb_en,
  output logic              o_mem_wb_flush,
  output logic              o_imem_ren,
  output logic              o_dmem_ren,
  output logic              o_dmem_wen,
  output logic              o_halt,
  output logic              o_dwait,
  output logic [PERF_W-1:0] o_cyc_cnt,
  output logic [PERF_W-1:0] o_stall_cnt,
  output logic [PERF_W-1:0] o_flush_cnt
);

  typedef enum logic [1:0] {StRun, StDwait, StHalt} state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic              w_dstall;
  logic              w_redirect;
  logic              w_load_use;
  logic              w_squash;
  logic [PERF_W-1:0] r_cyc_cnt;
  logic [PERF_W-1:0] r_stall_cnt;
  logic [PERF_W-1:0] r_flush_cnt;

  assign w_dstall   = (i_mem_dren | i_mem_dwen) & ~i_dhit;
  assign w_redirect = i_ex_redirect & i_ihit;
  assign w_load_use = i_ex_dren & (i_ex_wsel != 5'd0) &
                      ((i_ex_wsel == i_id_rs) | (i_id_uses_rt & (i_ex_wsel == i_id_rt)));
  // A redirect only squashes when no D-stall freezes the front of the pipe.
  assign w_squash   = ~i_rst & (r_state != StHalt) & ~w_dstall & w_redirect;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StRun;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (i_wb_halt) begin
      w_state_next = StHalt;
    end else begin
      case (r_state)
        StRun:   if (w_dstall) w_state_next = StDwait;
        StDwait: if (i_dhit) w_state_next = StRun;
        default: w_state_next = StHalt;
      endcase
    end
  end

  always_comb begin
    o_pc_en        = 1'b0;
    o_if_id_en     = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_en     = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_ex_mem_en    = 1'b0;
    o_ex_mem_flush = 1'b0;
    o_mem_wb_en    = 1'b0;
    o_mem_wb_flush = 1'b0;
    o_imem_ren     = 1'b0;
    o_dmem_ren     = 1'b0;
    o_dmem_wen     = 1'b0;
    o_halt         = 1'b0;
    o_dwait        = 1'b0;
    if (i_rst) begin
      o_if_id_flush  = 1'b1;
      o_id_ex_flush  = 1'b1;
      o_ex_mem_flush = 1'b1;
      o_mem_wb_flush = 1'b1;
    end else if (r_state == StHalt) begin
      o_halt = 1'b1;
    end else begin
      o_imem_ren = 1'b1;
      o_dmem_ren = i_mem_dren;
      o_dmem_wen = i_mem_dwen;
      o_dwait    = (r_state == StDwait);
      if (w_dstall) begin
        o_mem_wb_en    = 1'b1;
        o_mem_wb_flush = 1'b1;
      end else if (w_redirect) begin
        o_pc_en       = 1'b1;
        o_if_id_en    = 1'b1;
        o_id_ex_en    = 1'b1;
        o_ex_mem_en   = 1'b1;
        o_mem_wb_en   = 1'b1;
        o_if_id_flush = 1'b1;
        o_id_ex_flush = 1'b1;
      end else if (!i_ihit || w_load_use) begin
        // Hold IF/ID and the PC, inject a bubble into ID/EX, let the back end drain.
        o_id_ex_en    = 1'b1;
        o_id_ex_flush = 1'b1;
        o_ex_mem_en   = 1'b1;
        o_mem_wb_en   = 1'b1;
      end else begin
        o_pc_en     = 1'b1;
        o_if_id_en  = 1'b1;
        o_id_ex_en  = 1'b1;
        o_ex_mem_en = 1'b1;
        o_mem_wb_en = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cyc_cnt   <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (r_state != StHalt) begin
      if (r_cyc_cnt != '1) r_cyc_cnt <= r_cyc_cnt + 1'b1;
      if (!o_pc_en && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_squash && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign o_cyc_cnt   = r_cyc_cnt;
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios then randomized traffic, every
// cycle compared against a behavioural model of the hazard rules.
module tb_pipeline_ctrl;

  localparam int unsigned PW  = 6;
  localparam int unsigned SAT = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ihit = 1'b0, dhit = 1'b0, mem_dren = 1'b0, mem_dwen = 1'b0, ex_dren = 1'b0;
  logic [4:0]    ex_wsel = '0, id_rs = '0, id_rt = '0;
  logic          id_uses_rt = 1'b0, ex_redirect = 1'b0, wb_halt = 1'b0;
  logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic          ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush;
  logic          imem_ren, dmem_ren, dmem_wen, halt, dwait;
  logic [PW-1:0] cyc_cnt, stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl #(.PERF_W(PW)) dut (
    .i_clk(clk), .i_rst(rst), .i_ihit(ihit), .i_dhit(dhit), .i_mem_dren(mem_dren),
    .i_mem_dwen(mem_dwen), .i_ex_dren(ex_dren), .i_ex_wsel(ex_wsel), .i_id_rs(id_rs),
    .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt), .i_ex_redirect(ex_redirect),
    .i_wb_halt(wb_halt), .o_pc_en(pc_en), .o_if_id_en(if_id_en),
    .o_if_id_flush(if_id_flush), .o_id_ex_en(id_ex_en), .o_id_ex_flush(id_ex_flush),
    .o_ex_mem_en(ex_mem_en), .o_ex_mem_flush(ex_mem_flush), .o_mem_wb_en(mem_wb_en),
    .o_mem_wb_flush(mem_wb_flush), .o_imem_ren(imem_ren), .o_dmem_ren(dmem_ren),
    .o_dmem_wen(dmem_wen), .o_halt(halt), .o_dwait(dwait), .o_cyc_cnt(cyc_cnt),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: waiting on D-cache, halted, counters known after the first reset edge.
  bit m_wait  = 1'b0;
  bit m_halt  = 1'b0;
  bit m_known = 1'b0;
  int m_cyc   = 0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit dstall_now();
    return (mem_dren || mem_dwen) && !dhit;
  endfunction

  function automatic bit load_use_now();
    return ex_dren && (ex_wsel != 0) &&
           (ex_wsel == id_rs || (id_uses_rt && ex_wsel == id_rt));
  endfunction

  // Pipe vectors are ordered {MEM_WB, EX_MEM, ID_EX, IF_ID}.
  task automatic check_cycle(input string tag);
    bit [3:0] en, fl;
    bit       pc, im, dr, dw, h, dwt;
    if (rst) begin
      en = 4'b0000; fl = 4'b1111; pc = 0; im = 0; dr = 0; dw = 0; h = 0; dwt = 0;
    end else if (m_halt) begin
      en = 4'b0000; fl = 4'b0000; pc = 0; im = 0; dr = 0; dw = 0; h = 1; dwt = 0;
    end else begin
      im = 1; dr = mem_dren; dw = mem_dwen; h = 0; dwt = m_wait;
      en = 4'b1111; fl = 4'b0000; pc = 1;
      if (dstall_now()) begin
        en = 4'b1000; fl = 4'b1000; pc = 0;
      end else if (ex_redirect && ihit) begin
        fl = 4'b0011;
      end else if (!ihit || load_use_now()) begin
        en = 4'b1110; fl = 4'b0010; pc = 0;
      end
    end
    check({tag, ".pc_en"}, pc_en, pc);
    check({tag, ".en"}, {mem_wb_en, ex_mem_en, id_ex_en, if_id_en}, en);
    check({tag, ".flush"}, {mem_wb_flush, ex_mem_flush, id_ex_flush, if_id_flush}, fl);
    check({tag, ".imem"}, imem_ren, im);
    check({tag, ".dreq"}, {dmem_ren, dmem_wen}, {dr, dw});
    check({tag, ".halt"}, halt, h);
    check({tag, ".dwait"}, dwait, dwt);
    if (m_known) begin
      check({tag, ".cyc"}, cyc_cnt, m_cyc);
      check({tag, ".stall"}, stall_cnt, m_stall);
      check({tag, ".flushc"}, flush_cnt, m_flush);
    end
  endtask

  task automatic model_clock();
    bit ds, stalled, squash;
    ds      = dstall_now();
    stalled = ds || !ihit || (load_use_now() && !ex_redirect);
    squash  = !ds && ex_redirect && ihit;
    if (rst) begin
      m_wait = 0; m_halt = 0; m_known = 1; m_cyc = 0; m_stall = 0; m_flush = 0;
    end else if (!m_halt) begin
      if (m_cyc < SAT) m_cyc++;
      if (stalled && m_stall < SAT) m_stall++;
      if (squash && m_flush < SAT) m_flush++;
      if (wb_halt) m_halt = 1;
      else if (ds) m_wait = 1;
      else if (dhit) m_wait = 0;
    end
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    check_cycle(tag);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic quiet();
    rst = 0; ihit = 1; dhit = 0; mem_dren = 0; mem_dwen = 0; ex_dren = 0;
    ex_wsel = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_redirect = 0; wb_halt = 0;
  endtask

  initial begin
    int s0;
    int c0;
    rst = 1;
    cycle("reset");
    cycle("reset");

    quiet();
    for (int i = 0; i < 5; i++) cycle("run");
    check("run.cyc5", cyc_cnt, 5);
    check("run.stall0", stall_cnt, 0);

    // D-cache miss for three cycles, then hit
    mem_dren = 1;
    for (int i = 0; i < 3; i++) cycle("dmiss");
    dhit = 1;
    cycle("dhit");
    check("dmiss.stall3", stall_cnt, 3);
    check("dmiss.run", dwait, 0);
    quiet();

    ex_dren = 1; ex_wsel = 8; id_rs = 8;
    cycle("loaduse");
    check("loaduse.stall", stall_cnt, 4);
    ex_wsel = 0; id_rs = 0;
    cycle("loaduse.r0");
    check("loaduse.r0.stall", stall_cnt, 4);
    ex_wsel = 9; id_rt = 9; id_uses_rt = 1;
    cycle("loaduse.rt");

    ex_wsel = 8; id_rs = 8; id_uses_rt = 0; ex_redirect = 1;
    cycle("redirect.lu");
    check("redirect.flush1", flush_cnt, 1);
    quiet();

    ex_redirect = 1; ihit = 0;
    cycle("redirect.imiss");
    cycle("redirect.imiss");
    ihit = 1;
    cycle("redirect.ihit");
    check("redirect.flush2", flush_cnt, 2);
    quiet();

    // Halt arriving while waiting on the D-cache
    mem_dren = 1;
    cycle("halt.dmiss");
    cycle("halt.dwait");
    wb_halt = 1;
    cycle("halt.pulse");
    wb_halt = 0;
    c0 = cyc_cnt;
    for (int i = 0; i < 3; i++) cycle("halted");
    check("halted.frozen", cyc_cnt, c0);
    check("halted.dren", dmem_ren, 0);
    rst = 1;
    cycle("halt.rst");
    quiet();
    check("halt.rst.cyc0", cyc_cnt, 0);
    check("halt.rst.run", halt, 0);

    for (int i = 0; i < SAT + 8; i++) cycle("sat");
    check("sat.cyc", cyc_cnt, SAT);

    for (int i = 0; i < 800; i++) begin
      rst         = ($urandom_range(0, 59) == 0);
      wb_halt     = ($urandom_range(0, 89) == 0);
      ihit        = ($urandom_range(0, 3) != 0);
      dhit        = $urandom_range(0, 1);
      mem_dren    = ($urandom_range(0, 9) < 3);
      mem_dwen    = ($urandom_range(0, 9) < 2);
      ex_dren     = $urandom_range(0, 1);
      ex_wsel     = 5'($urandom_range(0, 3));
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      id_uses_rt  = $urandom_range(0, 1);
      ex_redirect = ($urandom_range(0, 4) == 0);
      cycle("rand");
    end
    s0 = n_fail;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, s0);
    $finish;
  end

endmodule
